// File: rtl/svi_rr_arbiter_if.sv
// svi_rr_arbiter_if: requester-side and svi-side signal bundle of svi_rr_arbiter.
// master is the arbiter's view; slave is the view of whatever drives requests and answers svi.
interface svi_rr_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int AW    = 16,
    parameter int DW    = 32
);
    logic [N_REQ-1:0]         req_valid;
    logic [N_REQ-1:0]         req_we;
    logic [N_REQ*AW-1:0]      req_addr;
    logic [N_REQ*DW-1:0]      req_wdata;
    logic [N_REQ-1:0]         req_ack;
    logic                     req_err;
    logic [DW-1:0]            req_rdata;
    logic                     svi_valid;
    logic                     svi_ready;
    logic                     svi_we;
    logic [AW-1:0]            svi_addr;
    logic [DW-1:0]            svi_wdata;
    logic                     svi_rvalid;
    logic [DW-1:0]            svi_rdata;
    logic                     busy;
    logic [$clog2(N_REQ)-1:0] grant_id;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, svi_ready, svi_rvalid, svi_rdata,
        output req_ack, req_err, req_rdata, svi_valid, svi_we, svi_addr, svi_wdata, busy, grant_id
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, svi_ready, svi_rvalid, svi_rdata,
        input  req_ack, req_err, req_rdata, svi_valid, svi_we, svi_addr, svi_wdata, busy, grant_id
    );
endinterface

// File: rtl/svi_rr_arbiter.sv
// svi_rr_arbiter: round-robin sharing of one svi master port between N_REQ requesters,
// one transaction at a time, with a watchdog bounding how long a read waits for its response.
module svi_rr_arbiter #(
    parameter int N_REQ       = 4,
    parameter int AW          = 16,
    parameter int DW          = 32,
    parameter int TIMEOUT_CYC = 16,
    parameter int TCQ         = 100
) (
    input logic              clk,
    input logic              rst,
    svi_rr_arbiter_if.master bus
);
    localparam int IW = $clog2(N_REQ);
    localparam int TW = $clog2(TIMEOUT_CYC);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, DONE} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d, gid_q, gid_d, win_id, idx;
    logic          we_q, we_d, err_q, err_d, win_found;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic [TW-1:0] timer_q, timer_d;

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 2 || TCQ < 0) begin : g_bad_cfg
        $error("svi_rr_arbiter: unsupported parameter set");
    end

    // Scan downward so the lowest rotation distance from ptr overwrites last and wins.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        idx       = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = IW'((int'(ptr_q) + k) % N_REQ);
            if (bus.req_valid[idx]) begin
                win_found = 1'b1;
                win_id    = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gid_d   = gid_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        timer_d = timer_q;
        case (state_q)
            IDLE: if (win_found) begin
                state_d = ISSUE;
                gid_d   = win_id;
                we_d    = bus.req_we[win_id];
                addr_d  = bus.req_addr[int'(win_id)*AW +: AW];
                wdata_d = bus.req_wdata[int'(win_id)*DW +: DW];
            end
            ISSUE: if (bus.svi_ready) begin
                state_d = we_q ? DONE : WAIT_RSP;
                timer_d = '0;
                if (we_q) begin
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            // A response arriving on the expiry cycle still counts as success.
            WAIT_RSP: begin
                timer_d = timer_q + 1'b1;
                if (bus.svi_rvalid || timer_q == TW'(TIMEOUT_CYC - 1)) begin
                    state_d = DONE;
                    rdata_d = bus.svi_rvalid ? bus.svi_rdata : '0;
                    err_d   = !bus.svi_rvalid;
                end
            end
            DONE: begin
                state_d = IDLE;
                ptr_d   = (gid_q == IW'(N_REQ - 1)) ? '0 : gid_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gid_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            timer_q <= timer_d;
        end
    end

    assign bus.req_ack   = (state_q == DONE) ? {{(N_REQ-1){1'b0}}, 1'b1} << gid_q : '0;
    assign bus.req_err   = err_q;
    assign bus.req_rdata = rdata_q;
    assign bus.svi_valid = state_q == ISSUE;
    assign bus.svi_we    = we_q;
    assign bus.svi_addr  = addr_q;
    assign bus.svi_wdata = wdata_q;
    assign bus.busy      = state_q != IDLE;
    assign bus.grant_id  = gid_q;
endmodule

// File: tb/tb_svi_rr_arbiter.sv
// tb_svi_rr_arbiter: vector table of writes, hand-written corner sequences, then randomized
// transactions checked against a rotation-and-search reference model.
module tb_svi_rr_arbiter;
    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int TO = 16;
    localparam int IW = $clog2(N);

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;

    svi_rr_arbiter_if #(.N_REQ(N), .AW(AW), .DW(DW)) bus();

    svi_rr_arbiter #(.N_REQ(N), .AW(AW), .DW(DW), .TIMEOUT_CYC(TO), .TCQ(100)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] valid;
        logic [N-1:0] exp_ack;
        int           exp_gid;
    } vec_t;

    vec_t         tbl[12];
    logic [N-1:0] rr_exp[5];
    int           got_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_fields();
        for (int i = 0; i < N; i++) begin
            bus.req_we[i]              = 1'b1;
            bus.req_addr[i*AW +: AW]   = AW'(16'h0010 + 16'h0100 * i);
            bus.req_wdata[i*DW +: DW]  = 32'hDEADBEEF ^ i;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        int           cnt, ptr_m, w, d, cyc;
        logic [N-1:0] mask;
        logic         e_we;
        logic [AW-1:0] e_a;
        logic [DW-1:0] e_d, rd;

        tbl[0]  = '{4'b0001, 4'b0001, 0};
        tbl[1]  = '{4'b0001, 4'b0001, 0};
        tbl[2]  = '{4'b1001, 4'b1000, 3};
        tbl[3]  = '{4'b1001, 4'b0001, 0};
        tbl[4]  = '{4'b0110, 4'b0010, 1};
        tbl[5]  = '{4'b0110, 4'b0100, 2};
        tbl[6]  = '{4'b0011, 4'b0001, 0};
        tbl[7]  = '{4'b1111, 4'b0010, 1};
        tbl[8]  = '{4'b0001, 4'b0001, 0};
        tbl[9]  = '{4'b1100, 4'b0100, 2};
        tbl[10] = '{4'b1100, 4'b1000, 3};
        tbl[11] = '{4'b1000, 4'b1000, 3};
        rr_exp  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        bus.req_valid  = '0;
        bus.req_we     = '0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.svi_ready  = 1'b0;
        bus.svi_rvalid = 1'b0;
        bus.svi_rdata  = '0;
        repeat (2) tick();
        chk("rst_busy", bus.busy, 0);
        chk("rst_svi_valid", bus.svi_valid, 0);
        chk("rst_ack", bus.req_ack, 0);
        chk("rst_gid", bus.grant_id, 0);
        chk("rst_err", bus.req_err, 0);
        chk("rst_rdata", bus.req_rdata, 0);
        chk("rst_addr", bus.svi_addr, 0);
        @(negedge clk) rst = 1'b0;

        // Table of write transactions with svi_ready already high.
        set_fields();
        for (int v = 0; v < 12; v++) begin
            bus.req_valid = tbl[v].valid;
            bus.svi_ready = 1'b1;
            tick();
            chk("tbl_svi_valid", bus.svi_valid, 1);
            chk("tbl_gid", bus.grant_id, tbl[v].exp_gid);
            chk("tbl_addr", bus.svi_addr, 16'h0010 + 16'h0100 * tbl[v].exp_gid);
            chk("tbl_wdata", bus.svi_wdata, 32'hDEADBEEF ^ tbl[v].exp_gid);
            chk("tbl_we", bus.svi_we, 1);
            tick();
            chk("tbl_ack", bus.req_ack, tbl[v].exp_ack);
            chk("tbl_svi_valid_drop", bus.svi_valid, 0);
            chk("tbl_err", bus.req_err, 0);
            chk("tbl_rdata", bus.req_rdata, 0);
            bus.req_valid = '0;
            tick();
            chk("tbl_idle", bus.busy, 0);
            chk("tbl_ack_pulse", bus.req_ack, 0);
        end

        // Read from requester 2 under 5 cycles of backpressure; fields must stay latched.
        bus.req_valid                = 4'b0100;
        bus.req_we                   = '0;
        bus.req_addr[2*AW +: AW]     = 16'h0200;
        bus.svi_ready                = 1'b0;
        tick();
        for (int c = 0; c < 5; c++) begin
            bus.req_addr[2*AW +: AW] = 16'hBAD0 + 16'(c);
            bus.svi_rvalid           = 1'b1;
            bus.svi_rdata            = 32'hFFFFFFFF;
            chk("bp_svi_valid", bus.svi_valid, 1);
            chk("bp_addr", bus.svi_addr, 16'h0200);
            chk("bp_we", bus.svi_we, 0);
            tick();
        end
        chk("bp_still_issue", bus.svi_valid, 1);
        bus.svi_ready = 1'b1;
        tick();
        bus.svi_ready = 1'b0;
        chk("bp_valid_drop", bus.svi_valid, 0);
        chk("bp_busy", bus.busy, 1);
        chk("bp_no_early_ack", bus.req_ack, 0);
        bus.svi_rvalid = 1'b1;
        bus.svi_rdata  = 32'h12345678;
        tick();
        chk("bp_ack", bus.req_ack, 4'b0100);
        chk("bp_rdata", bus.req_rdata, 32'h12345678);
        chk("bp_err", bus.req_err, 0);
        bus.req_valid  = '0;
        bus.svi_rvalid = 1'b0;
        tick();

        // Read from requester 1 that never gets a response.
        bus.req_valid = 4'b0010;
        bus.svi_ready = 1'b1;
        tick();
        chk("to_gid", bus.grant_id, 1);
        tick();
        cnt = 0;
        while (bus.req_ack == 0 && cnt < 40) begin
            tick();
            cnt++;
        end
        chk("to_latency", cnt, TO);
        chk("to_ack", bus.req_ack, 4'b0010);
        chk("to_err", bus.req_err, 1);
        chk("to_rdata", bus.req_rdata, 0);
        bus.req_valid  = '0;
        bus.svi_rvalid = 1'b1;
        bus.svi_rdata  = 32'hFEEDFACE;
        repeat (3) tick();
        chk("late_busy", bus.busy, 0);
        chk("late_ack", bus.req_ack, 0);
        chk("late_rdata_hold", bus.req_rdata, 0);
        chk("late_err_hold", bus.req_err, 1);
        bus.svi_rvalid = 1'b0;

        // Response on the last allowed cycle beats the timeout.
        bus.req_valid = 4'b0100;
        tick();
        chk("co_gid", bus.grant_id, 2);
        tick();
        repeat (TO - 1) tick();
        chk("co_still_wait", bus.busy, 1);
        chk("co_no_ack", bus.req_ack, 0);
        bus.svi_rvalid = 1'b1;
        bus.svi_rdata  = 32'hA5A5A5A5;
        tick();
        chk("co_ack", bus.req_ack, 4'b0100);
        chk("co_err", bus.req_err, 0);
        chk("co_rdata", bus.req_rdata, 32'hA5A5A5A5);
        bus.req_valid  = '0;
        bus.svi_rvalid = 1'b0;
        tick();

        // Asynchronous reset in the middle of a read wait.
        bus.req_valid = 4'b0001;
        repeat (4) tick();
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", bus.busy, 0);
        chk("arst_svi_valid", bus.svi_valid, 0);
        chk("arst_ack", bus.req_ack, 0);
        chk("arst_gid", bus.grant_id, 0);
        chk("arst_rdata", bus.req_rdata, 0);
        bus.req_valid = '0;
        @(negedge clk);
        @(negedge clk) rst = 1'b0;
        tick();
        chk("arst_no_ack", bus.req_ack, 0);
        set_fields();
        bus.req_valid = 4'b1001;
        tick();
        chk("arst_ptr0_gid", bus.grant_id, 0);
        tick();
        chk("arst_ptr0_ack", bus.req_ack, 4'b0001);
        bus.req_valid = '0;
        tick();
        bus.req_valid = 4'b1000;
        tick();
        chk("arst_req3_gid", bus.grant_id, 3);
        tick();
        chk("arst_req3_ack", bus.req_ack, 4'b1000);
        bus.req_valid = '0;
        tick();

        // All four hold reads; each is granted once per rotation.
        bus.req_valid  = 4'b1111;
        bus.req_we     = '0;
        bus.svi_rvalid = 1'b1;
        bus.svi_rdata  = 32'h0BADCAFE;
        for (int c = 0; c < 30 && got_q.size() < 5; c++) begin
            tick();
            if (bus.req_ack != 0) got_q.push_back(int'(bus.req_ack));
        end
        for (int i = 0; i < 5; i++)
            chk("rr_order", (got_q.size() > i) ? got_q[i] : -1, rr_exp[i]);
        bus.req_valid  = '0;
        bus.svi_rvalid = 1'b0;
        tick();

        // Randomized transactions against the reference model.
        ptr_m = 1;
        for (int t = 0; t < 150; t++) begin
            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                bus.req_we[i]             = 1'($urandom);
                bus.req_addr[i*AW +: AW]  = AW'($urandom);
                bus.req_wdata[i*DW +: DW] = $urandom;
            end
            w = -1;
            for (int s = 0; s < N && w < 0; s++)
                if (mask[IW'((ptr_m + s) % N)]) w = (ptr_m + s) % N;
            e_we = bus.req_we[w];
            e_a  = bus.req_addr[w*AW +: AW];
            e_d  = bus.req_wdata[w*DW +: DW];
            bus.req_valid  = mask;
            bus.svi_ready  = 1'b0;
            bus.svi_rvalid = 1'b0;
            tick();
            chk("rnd_gid", bus.grant_id, w);
            chk("rnd_svi_valid", bus.svi_valid, 1);
            chk("rnd_we", bus.svi_we, e_we);
            chk("rnd_addr", bus.svi_addr, e_a);
            chk("rnd_wdata", bus.svi_wdata, e_d);
            for (int i = 0; i < N; i++) begin
                bus.req_we[i]             = 1'($urandom);
                bus.req_addr[i*AW +: AW]  = AW'($urandom);
                bus.req_wdata[i*DW +: DW] = $urandom;
            end
            d = $urandom_range(0, 3);
            for (int c = 0; c < d; c++) begin
                bus.svi_rvalid = 1'($urandom);
                tick();
            end
            chk("rnd_hold_valid", bus.svi_valid, 1);
            chk("rnd_hold_addr", bus.svi_addr, e_a);
            chk("rnd_hold_wdata", bus.svi_wdata, e_d);
            bus.svi_ready  = 1'b1;
            bus.svi_rvalid = 1'($urandom);
            tick();
            bus.svi_ready  = 1'b0;
            rd  = $urandom;
            d   = $urandom_range(0, 20);
            cyc = 0;
            while (bus.req_ack == 0 && cyc < 24) begin
                bus.svi_rvalid = (cyc == d);
                bus.svi_rdata  = rd;
                tick();
                cyc++;
            end
            bus.svi_rvalid = 1'b0;
            chk("rnd_latency", cyc, e_we ? 0 : (d < TO ? d + 1 : TO));
            chk("rnd_ack", bus.req_ack, 1 << w);
            chk("rnd_err", bus.req_err, !e_we && d >= TO);
            chk("rnd_rdata", bus.req_rdata, (e_we || d >= TO) ? 32'h0 : rd);
            bus.req_valid = '0;
            tick();
            chk("rnd_idle", bus.busy, 0);
            ptr_m = (w + 1) % N;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
